// File: rtl/hist_edit_sequencer_pkg.sv
// hist_edit_sequencer_pkg: key codes, FSM state encoding and the key-event
// record shared by the line-edit sequencer and its pending-event slot.
package hist_edit_sequencer_pkg;

  // Key event type values carried on i_type
  localparam logic KEY_TYPE_CHAR = 1'b0;
  localparam logic KEY_TYPE_CTRL = 1'b1;

  // Control codes carried on i_asciiex when i_type is KEY_TYPE_CTRL
  localparam logic [7:0] KEY_CODE_RIGHT     = 8'h01;
  localparam logic [7:0] KEY_CODE_DOWN      = 8'h02;
  localparam logic [7:0] KEY_CODE_LEFT      = 8'h03;
  localparam logic [7:0] KEY_CODE_BACKSPACE = 8'h08;

  // Blank character used for erasing and for the "past end of line" display
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_COMMIT,
    ST_CLEAR
  } state_t;

  typedef struct packed {
    logic       typ;
    logic [7:0] code;
  } key_ev_t;

  // Edit operation selected by one key event
  typedef enum logic [2:0] {
    OP_CHAR,
    OP_LEFT,
    OP_RIGHT,
    OP_DOWN,
    OP_BACKSPACE,
    OP_BAD
  } op_t;

  function automatic op_t decode_op(input key_ev_t ev);
    if (ev.typ == KEY_TYPE_CHAR) return OP_CHAR;
    case (ev.code)
      KEY_CODE_RIGHT:     return OP_RIGHT;
      KEY_CODE_DOWN:      return OP_DOWN;
      KEY_CODE_LEFT:      return OP_LEFT;
      KEY_CODE_BACKSPACE: return OP_BACKSPACE;
      default:            return OP_BAD;
    endcase
  endfunction

endpackage

// File: rtl/hist_edit_sequencer_ev_slot.sv
// hist_edit_sequencer_ev_slot: one-entry holding buffer for a key event that
// arrives while the sequencer is busy. A push into a full slot is refused
// (drop) unless the slot is being popped in the same cycle.
module hist_edit_sequencer_ev_slot
  import hist_edit_sequencer_pkg::*;
(
  input  logic    clk,
  input  logic    i_arst_n,
  input  logic    push,
  input  key_ev_t push_ev,
  input  logic    pop,
  output logic    valid,
  output key_ev_t ev,
  output logic    drop
);

  assign drop = push && valid && !pop;

  // Slot contents: load on an accepted push, empty on a pop with no refill
  // NOTE: state is updated with non-blocking assignments so every register
  // in the design samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      valid <= 1'b0;
      ev    <= '0;
    end else if (push && (!valid || pop)) begin
      valid <= 1'b1;
      ev    <= push_ev;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/hist_edit_sequencer.sv
// hist_edit_sequencer: line-edit controller between the key decoder and the
// history RAM. Tracks cursor and line length, sequences RAM write/read-back
// per edit, and commits the line to the history indexer on DOWN.
// Optional feature: define HIST_EDIT_CLEAR_ON_COMMIT_EN to blank the
// committed line in RAM (CLEAR state) before returning to IDLE.
module hist_edit_sequencer
  import hist_edit_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  i_arst_n,
  input  logic                  i_ev_valid,
  input  logic                  i_type,
  input  logic [7:0]            i_asciiex,
  output logic                  o_ready,
  output logic                  o_drop,
  output logic                  o_ram_we,
  output logic                  o_ram_re,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [7:0]            o_ram_wdata,
  input  logic [7:0]            i_ram_rdata,
  output logic [ADDR_WIDTH:0]   o_cursor,
  output logic [ADDR_WIDTH:0]   o_len,
  output logic [7:0]            o_disp_char,
  output logic                  o_disp_valid,
  output logic                  o_history_en,
  output logic [ADDR_WIDTH:0]   o_commit_len
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t              state;
  logic                wr_is_bs;
  logic                slot_valid;
  logic                slot_drop;
  logic                slot_push;
  logic                slot_pop;
  key_ev_t             slot_ev;
  key_ev_t             in_ev;
  key_ev_t             cur_ev;
  logic                ev_go;
  op_t                 op;
  logic                at_end;
  logic [ADDR_WIDTH:0] cur_inc;
  logic [ADDR_WIDTH:0] cur_dec;
  logic [ADDR_WIDTH:0] len_inc;
  logic [ADDR_WIDTH:0] len_dec;
  logic [ADDR_WIDTH:0] left_cur;
  logic [ADDR_WIDTH:0] right_cur;

  // Event arbitration: a held event always executes before a new one, and
  // anything arriving while busy (or behind a held event) goes to the slot.
  assign in_ev     = '{typ: i_type, code: i_asciiex};
  assign slot_pop  = (state == ST_IDLE) && slot_valid;
  assign slot_push = i_ev_valid && ((state != ST_IDLE) || slot_valid);
  assign ev_go     = (state == ST_IDLE) && (slot_valid || i_ev_valid);
  assign cur_ev    = slot_valid ? slot_ev : in_ev;
  assign op        = decode_op(cur_ev);
  assign o_ready   = !slot_valid;

  // Cursor arithmetic shared by the edit and movement paths
  assign at_end    = (o_cursor == o_len);
  assign cur_inc   = o_cursor + ONE;
  assign cur_dec   = o_cursor - ONE;
  assign len_inc   = o_len + ONE;
  assign len_dec   = o_len - ONE;
  assign left_cur  = (o_cursor == '0) ? o_cursor : cur_dec;
  assign right_cur = at_end ? o_cursor : cur_inc;

`ifdef HIST_EDIT_CLEAR_ON_COMMIT_EN
  logic clear_last;
  assign clear_last = (({1'b0, o_ram_addr} + ONE) == o_len);
`endif

  hist_edit_sequencer_ev_slot u_ev_slot (
    .clk      (clk),
    .i_arst_n (i_arst_n),
    .push     (slot_push),
    .push_ev  (in_ev),
    .pop      (slot_pop),
    .valid    (slot_valid),
    .ev       (slot_ev),
    .drop     (slot_drop)
  );

  // Edit FSM with registered RAM strobes, display and commit outputs
  always_ff @(posedge clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state        <= ST_IDLE;
      wr_is_bs     <= 1'b0;
      o_cursor     <= '0;
      o_len        <= '0;
      o_ram_we     <= 1'b0;
      o_ram_re     <= 1'b0;
      o_ram_addr   <= '0;
      o_ram_wdata  <= '0;
      o_disp_char  <= ASCII_SPACE;
      o_disp_valid <= 1'b0;
      o_history_en <= 1'b0;
      o_commit_len <= '0;
      o_drop       <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here and are raised only by the
      // branch that owns them, so each stays high for exactly one cycle.
      o_disp_valid <= 1'b0;
      o_history_en <= 1'b0;
      o_drop       <= slot_drop;

      case (state)
        ST_IDLE: begin
          if (ev_go) begin
            case (op)
              OP_CHAR: begin
                if (o_cursor == DEPTH) begin
                  o_drop <= 1'b1;
                end else begin
                  state       <= ST_WRITE;
                  wr_is_bs    <= 1'b0;
                  o_ram_we    <= 1'b1;
                  o_ram_addr  <= o_cursor[ADDR_WIDTH-1:0];
                  o_ram_wdata <= cur_ev.code;
                end
              end
              OP_BACKSPACE: begin
                if (o_cursor != '0) begin
                  state       <= ST_WRITE;
                  wr_is_bs    <= 1'b1;
                  o_ram_we    <= 1'b1;
                  o_ram_addr  <= cur_dec[ADDR_WIDTH-1:0];
                  o_ram_wdata <= ASCII_SPACE;
                end
              end
              OP_LEFT: begin
                state      <= ST_RD_REQ;
                o_cursor   <= left_cur;
                o_ram_re   <= 1'b1;
                o_ram_addr <= left_cur[ADDR_WIDTH-1:0];
              end
              OP_RIGHT: begin
                state      <= ST_RD_REQ;
                o_cursor   <= right_cur;
                o_ram_re   <= 1'b1;
                o_ram_addr <= right_cur[ADDR_WIDTH-1:0];
              end
              OP_DOWN: begin
                if (o_len != '0) begin
                  state        <= ST_COMMIT;
                  o_history_en <= 1'b1;
                  o_commit_len <= o_len;
                end
              end
              default: begin
                o_drop <= 1'b1;
              end
            endcase
          end
        end

        ST_WRITE: begin
          state    <= ST_RD_REQ;
          o_ram_we <= 1'b0;
          o_ram_re <= 1'b1;
          if (wr_is_bs) begin
            o_cursor   <= cur_dec;
            o_ram_addr <= cur_dec[ADDR_WIDTH-1:0];
            if (at_end) o_len <= len_dec;
          end else begin
            o_cursor   <= cur_inc;
            o_ram_addr <= cur_inc[ADDR_WIDTH-1:0];
            if (at_end) o_len <= len_inc;
          end
        end

        ST_RD_REQ: begin
          state    <= ST_RD_WAIT;
          o_ram_re <= 1'b0;
        end

        ST_RD_WAIT: begin
          state        <= ST_IDLE;
          o_disp_char  <= at_end ? ASCII_SPACE : i_ram_rdata;
          o_disp_valid <= 1'b1;
        end

        ST_COMMIT: begin
`ifdef HIST_EDIT_CLEAR_ON_COMMIT_EN
          state       <= ST_CLEAR;
          o_ram_we    <= 1'b1;
          o_ram_addr  <= '0;
          o_ram_wdata <= ASCII_SPACE;
`else
          state        <= ST_IDLE;
          o_cursor     <= '0;
          o_len        <= '0;
          o_disp_char  <= ASCII_SPACE;
          o_disp_valid <= 1'b1;
`endif
        end

`ifdef HIST_EDIT_CLEAR_ON_COMMIT_EN
        // One blanking write per cycle over addresses 0..len-1
        ST_CLEAR: begin
          if (clear_last) begin
            state        <= ST_IDLE;
            o_ram_we     <= 1'b0;
            o_cursor     <= '0;
            o_len        <= '0;
            o_disp_char  <= ASCII_SPACE;
            o_disp_valid <= 1'b1;
          end else begin
            o_ram_addr <= o_ram_addr + 1'b1;
          end
        end
`endif

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hist_edit_sequencer.sv
// tb_hist_edit_sequencer: self-checking bench for hist_edit_sequencer.
// A behavioural line model (array + cursor + length) predicts every edit;
// a small RAM model sits on the DUT's RAM port. Honours
// HIST_EDIT_CLEAR_ON_COMMIT_EN when predicting commit behaviour.
`timescale 1ns/1ps
module tb_hist_edit_sequencer;

  localparam int AW     = 4;
  localparam int DEPTH  = 16;
  localparam int WINDOW = 22;

  typedef enum int {K_EDIT, K_MOVE, K_COMMIT, K_NOP, K_DROP} kind_t;

  logic          clk = 1'b0;
  logic          i_arst_n = 1'b1;
  logic          i_ev_valid = 1'b0;
  logic          i_type = 1'b0;
  logic [7:0]    i_asciiex = 8'h00;
  logic          o_ready;
  logic          o_drop;
  logic          o_ram_we;
  logic          o_ram_re;
  logic [AW-1:0] o_ram_addr;
  logic [7:0]    o_ram_wdata;
  logic [7:0]    i_ram_rdata = 8'h20;
  logic [AW:0]   o_cursor;
  logic [AW:0]   o_len;
  logic [7:0]    o_disp_char;
  logic          o_disp_valid;
  logic          o_history_en;
  logic [AW:0]   o_commit_len;

  int tests = 0;
  int fails = 0;

  hist_edit_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .i_arst_n     (i_arst_n),
    .i_ev_valid   (i_ev_valid),
    .i_type       (i_type),
    .i_asciiex    (i_asciiex),
    .o_ready      (o_ready),
    .o_drop       (o_drop),
    .o_ram_we     (o_ram_we),
    .o_ram_re     (o_ram_re),
    .o_ram_addr   (o_ram_addr),
    .o_ram_wdata  (o_ram_wdata),
    .i_ram_rdata  (i_ram_rdata),
    .o_cursor     (o_cursor),
    .o_len        (o_len),
    .o_disp_char  (o_disp_char),
    .o_disp_valid (o_disp_valid),
    .o_history_en (o_history_en),
    .o_commit_len (o_commit_len)
  );

  always #5 clk = ~clk;

  // History RAM model: synchronous write, read data valid the next cycle
  logic [7:0] ram [DEPTH] = '{default: 8'h20};
  logic       overlap_seen = 1'b0;
  always @(posedge clk) begin
    if (o_ram_we) ram[o_ram_addr] <= o_ram_wdata;
    if (o_ram_re) i_ram_rdata <= ram[o_ram_addr];
    if (o_ram_we && o_ram_re) overlap_seen <= 1'b1;
  end

  // Reference line model
  logic [7:0] mline [DEPTH] = '{default: 8'h20};
  int         mcur = 0;
  int         mlen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply one key event to the line model and report what the DUT must do
  task automatic model_apply(input logic typ, input logic [7:0] code,
                             output kind_t k, output int exp_disp,
                             output int exp_commit, output int exp_writes);
    exp_disp   = 32'h20;
    exp_commit = 0;
    exp_writes = 0;
    k          = K_NOP;
    if (typ == 1'b0) begin
      if (mcur == DEPTH) begin
        k = K_DROP;
      end else begin
        mline[mcur] = code;
        if (mcur == mlen) mlen++;
        mcur++;
        k = K_EDIT;
        exp_writes = 1;
      end
    end else begin
      case (code)
        8'h03: begin
          if (mcur > 0) mcur--;
          k = K_MOVE;
        end
        8'h01: begin
          if (mcur < mlen) mcur++;
          k = K_MOVE;
        end
        8'h08: begin
          if (mcur == 0) begin
            k = K_NOP;
          end else begin
            if (mcur == mlen) mlen--;
            mcur--;
            mline[mcur] = 8'h20;
            k = K_EDIT;
            exp_writes = 1;
          end
        end
        8'h02: begin
          if (mlen == 0) begin
            k = K_NOP;
          end else begin
            k = K_COMMIT;
            exp_commit = mlen;
`ifdef HIST_EDIT_CLEAR_ON_COMMIT_EN
            for (int i = 0; i < mlen; i++) mline[i] = 8'h20;
            exp_writes = mlen;
`endif
            mcur = 0;
            mlen = 0;
          end
        end
        default: k = K_DROP;
      endcase
    end
    if (k == K_EDIT || k == K_MOVE)
      exp_disp = (mcur == mlen) ? 32'h20 : 32'(mline[mcur]);
  endtask

  task automatic check_ram_image(input string tag);
    int mm;
    mm = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== mline[i]) mm++;
    check(tag, 32'(mm), 32'd0);
  endtask

  // Issue one event from IDLE, watch a fixed window, compare with the model
  task automatic run_event(input logic typ, input logic [7:0] code);
    kind_t k;
    int ed, ec, ew, exp_dcyc;
    int nw, nd, nh, ndrop, disp_cyc, hist_cyc, hist_len;
    logic [7:0] disp_ch;
    model_apply(typ, code, k, ed, ec, ew);
    i_ev_valid = 1'b1;
    i_type     = typ;
    i_asciiex  = code;
    step();
    i_ev_valid = 1'b0;
    nw = 0; nd = 0; nh = 0; ndrop = 0;
    disp_cyc = -1; hist_cyc = -1; hist_len = -1; disp_ch = 8'h00;
    for (int c = 1; c <= WINDOW; c++) begin
      if (o_ram_we) nw++;
      if (o_disp_valid) begin
        nd++;
        if (disp_cyc < 0) disp_cyc = c;
        disp_ch = o_disp_char;
      end
      if (o_history_en) begin
        nh++;
        hist_cyc = c;
        hist_len = 32'(o_commit_len);
      end
      if (o_drop) ndrop++;
      if (c < WINDOW) step();
    end
    exp_dcyc = (k == K_EDIT) ? 4 : (k == K_MOVE) ? 3 : 2;
`ifdef HIST_EDIT_CLEAR_ON_COMMIT_EN
    if (k == K_COMMIT) exp_dcyc = 2 + ec;
`endif
    check("ram_writes", 32'(nw), 32'(ew));
    check("drop_pulses", 32'(ndrop), (k == K_DROP) ? 32'd1 : 32'd0);
    check("disp_pulses", 32'(nd), (k == K_EDIT || k == K_MOVE || k == K_COMMIT) ? 32'd1 : 32'd0);
    if (nd == 1) begin
      check("disp_cycle", 32'(disp_cyc), 32'(exp_dcyc));
      check("disp_char", 32'(disp_ch), 32'(ed));
    end
    check("hist_pulses", 32'(nh), (k == K_COMMIT) ? 32'd1 : 32'd0);
    if (nh == 1) begin
      check("hist_cycle", 32'(hist_cyc), 32'd1);
      check("commit_len", 32'(hist_len), 32'(ec));
    end
    check("cursor", 32'(o_cursor), 32'(mcur));
    check("len", 32'(o_len), 32'(mlen));
    check("ready", 32'(o_ready), 32'd1);
    check_ram_image("ram_image");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},        32'(o_ram_we),     32'd0);
    check({tag, "_re"},        32'(o_ram_re),     32'd0);
    check({tag, "_addr"},      32'(o_ram_addr),   32'd0);
    check({tag, "_wdata"},     32'(o_ram_wdata),  32'd0);
    check({tag, "_cursor"},    32'(o_cursor),     32'd0);
    check({tag, "_len"},       32'(o_len),        32'd0);
    check({tag, "_disp_char"}, 32'(o_disp_char),  32'h20);
    check({tag, "_disp_vld"},  32'(o_disp_valid), 32'd0);
    check({tag, "_hist_en"},   32'(o_history_en), 32'd0);
    check({tag, "_commit"},    32'(o_commit_len), 32'd0);
    check({tag, "_drop"},      32'(o_drop),       32'd0);
    check({tag, "_ready"},     32'(o_ready),      32'd1);
  endtask

  initial begin
    kind_t dk;
    int d0, d1, d2, y_disp;
    logic [7:0] held;
    int r;

    // Reset, asserted asynchronously before any clock edge
    #1 i_arst_n = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) i_arst_n = 1'b1;
    step();

    // Type 'A','B'
    run_event(1'b0, 8'h41);
    run_event(1'b0, 8'h42);
    check("tp_ram0_A", 32'(ram[0]), 32'h41);
    check("tp_ram1_B", 32'(ram[1]), 32'h42);
    check("tp_cursor_2", 32'(o_cursor), 32'd2);
    check("tp_disp_space", 32'(o_disp_char), 32'h20);

    // LEFT, LEFT, 'C'
    run_event(1'b1, 8'h03);
    run_event(1'b1, 8'h03);
    run_event(1'b0, 8'h43);
    check("tp_ram0_C", 32'(ram[0]), 32'h43);
    check("tp_cursor_1", 32'(o_cursor), 32'd1);
    check("tp_len_2", 32'(o_len), 32'd2);
    check("tp_disp_B", 32'(o_disp_char), 32'h42);

    // RIGHT to end, BACKSPACE at cursor==len
    run_event(1'b1, 8'h01);
    run_event(1'b1, 8'h08);
    check("tp_bs_ram1", 32'(ram[1]), 32'h20);
    check("tp_bs_len", 32'(o_len), 32'd1);

    // BACKSPACE at 0 (no-op), RIGHT saturating at len
    run_event(1'b1, 8'h03);
    run_event(1'b1, 8'h08);
    run_event(1'b1, 8'h01);
    run_event(1'b1, 8'h01);
    check("tp_right_sat", 32'(o_cursor), 32'd1);

    // Build length 3 and commit, then DOWN on an empty line
    run_event(1'b0, 8'h44);
    run_event(1'b0, 8'h45);
    check("tp_len_3", 32'(o_len), 32'd3);
    run_event(1'b1, 8'h02);
    check("tp_commit_len_3", 32'(o_commit_len), 32'd3);
    run_event(1'b1, 8'h02);

    // Unknown control code
    run_event(1'b1, 8'h7F);

    // Three back-to-back events: execute, hold, drop
    model_apply(1'b0, 8'h58, dk, d0, d1, d2);
    i_ev_valid = 1'b1; i_type = 1'b0; i_asciiex = 8'h58;
    step();
    check("slot_we_first", 32'(o_ram_we), 32'd1);
    i_asciiex = 8'h59;
    step();
    check("slot_ready_low", 32'(o_ready), 32'd0);
    i_asciiex = 8'h5A;
    step();
    i_ev_valid = 1'b0;
    check("slot_drop", 32'(o_drop), 32'd1);
    check("slot_still_full", 32'(o_ready), 32'd0);
    step();
    check("slot_disp_first", 32'(o_disp_valid), 32'd1);
    step();
    check("slot_we_second", 32'(o_ram_we), 32'd1);
    check("slot_wdata_second", 32'(o_ram_wdata), 32'h59);
    check("slot_ready_again", 32'(o_ready), 32'd1);
    model_apply(1'b0, 8'h59, dk, y_disp, d1, d2);
    repeat (6) step();
    check("slot_cursor", 32'(o_cursor), 32'(mcur));
    check("slot_len", 32'(o_len), 32'(mlen));
    check("slot_disp_char", 32'(o_disp_char), 32'(y_disp));
    check_ram_image("slot_ram_image");

    // Fill the whole line, then one character too many
    run_event(1'b1, 8'h02);
    for (int i = 0; i < DEPTH; i++) run_event(1'b0, 8'(8'h61 + i));
    run_event(1'b0, 8'h7A);
    check("full_len_16", 32'(o_len), 32'd16);
    run_event(1'b1, 8'h02);

    // Randomised edits against the model
    for (int n = 0; n < 160; n++) begin
      r = $urandom_range(0, 11);
      if (r <= 4)       run_event(1'b0, 8'($urandom_range(33, 126)));
      else if (r == 5)  run_event(1'b1, 8'h03);
      else if (r == 6)  run_event(1'b1, 8'h01);
      else if (r <= 8)  run_event(1'b1, 8'h08);
      else if (r == 9)  run_event(1'b1, ($urandom_range(0, 2) == 0) ? 8'h02 : 8'h03);
      else if (r == 10) run_event(1'b1, 8'($urandom_range(9, 255)));
      else              run_event(1'b1, 8'($urandom_range(4, 7)));
    end

    // Reset asserted while a write is on the RAM port
    run_event(1'b1, 8'h02);
    held = ram[mcur];
    i_ev_valid = 1'b1; i_type = 1'b0; i_asciiex = 8'h52;
    step();
    i_ev_valid = 1'b0;
    check("rst_mid_we_before", 32'(o_ram_we), 32'd1);
    #2 i_arst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    step();
    check("rst_mid_no_write", 32'(ram[mcur]), 32'(held));
    mcur = 0;
    mlen = 0;
    @(negedge clk) i_arst_n = 1'b1;
    step();
    run_event(1'b0, 8'h51);
    check("we_re_overlap", 32'(overlap_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
